interleaver_pass_sequencer: RTL and testbench

Sequences the interleaver address counter (`{q, offset}` datapath, small/large block) through one complete block. It captures a block request and clears the counter before each of eight offset passes. It steps the counter one address per accepted beat against a downstream valid/ready handshake, checks `target_reached` against its own beat count, and flags completion. It sits between the block-level control logic and the counter wrapper, driving the wrapper's `count_enable`, `block_size` and `offset` inputs and the counter's clear.

---
 rtl/interleaver_pass_sequencer.sv | 140 ++++++++++++++
 tb/tb_interleaver_pass_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_pass_sequencer.sv
// interleaver_pass_sequencer: walks the {q, offset} counter through 8
// offset passes of one block, with handshake, checker and completion pulse.
//
// Ports:
//   clk, reset        clock, async active-low reset
//   start             block request (IDLE only)
//   block_size_in     0 = small (N=1056), 1 = large (N=6144)
//   abort             synchronous abandon of the current block
//   ready_out         downstream accepts the current address
//   target_reached    from counter wrapper, checked against beat count
//   busy              high outside IDLE
//   block_size        captured block size, to counter wrapper
//   offset            current pass offset, to counter wrapper
//   counter_clear     one-cycle counter clear
//   count_enable      addr_valid & ready_out, to counter wrapper
//   addr_valid        counter output is a valid address this cycle
//   block_done        one-cycle pulse after the final beat
//   seq_error         sticky target_reached mismatch flag
module interleaver_pass_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       block_size_in,
  input  logic       abort,
  input  logic       ready_out,
  input  logic       target_reached,
  output logic       busy,
  output logic       block_size,
  output logic [2:0] offset,
  output logic       counter_clear,
  output logic       count_enable,
  output logic       addr_valid,
  output logic       block_done,
  output logic       seq_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [9:0] LAST_SMALL = 10'd131;
  localparam logic [9:0] LAST_LARGE = 10'd767;
  localparam logic [2:0] LAST_OFF   = 3'd7;

  state_t     state_q, state_d;
  logic [9:0] beat_q, beat_d;
  logic [2:0] off_d;
  logic       size_d;
  logic       err_d;

  logic [9:0] last_beat;
  logic       pass_end;
  logic       final_beat;

  assign last_beat  = block_size ? LAST_LARGE : LAST_SMALL;
  assign pass_end   = (beat_q == last_beat);
  assign final_beat = pass_end && (offset == LAST_OFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      offset     <= '0;
      block_size <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      offset     <= off_d;
      block_size <= size_d;
      seq_error  <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    off_d         = offset;
    size_d        = block_size;
    err_d         = seq_error;
    busy          = (state_q != S_IDLE);
    counter_clear = 1'b0;
    count_enable  = 1'b0;
    addr_valid    = 1'b0;
    block_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          size_d  = block_size_in;
          off_d   = '0;
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        counter_clear = 1'b1;
        beat_d        = '0;
        state_d       = S_RUN;
      end
      S_RUN: begin
        addr_valid   = 1'b1;
        count_enable = ready_out;
        if (ready_out) begin
          if (target_reached != final_beat)
            err_d = 1'b1;
          if (!pass_end) begin
            beat_d = beat_q + 10'd1;
          end else if (offset != LAST_OFF) begin
            off_d   = offset + 3'd1;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        block_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything: the beat in flight is dropped, not
    // counted or checked, and the counter is cleared on the way out.
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      beat_d        = beat_q;
      off_d         = offset;
      err_d         = seq_error;
      counter_clear = 1'b1;
      count_enable  = 1'b0;
      block_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_interleaver_pass_sequencer.sv
// tb_interleaver_pass_sequencer: randomized bench with an attached counter
// model and an address-order reference built from beat index arithmetic.
module tb_interleaver_pass_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       block_size_in;
  logic       abort;
  logic       ready_out;
  logic       target_reached;
  logic       busy;
  logic       block_size;
  logic [2:0] offset;
  logic       counter_clear;
  logic       count_enable;
  logic       addr_valid;
  logic       block_done;
  logic       seq_error;

  int total = 0;
  int bad   = 0;

  interleaver_pass_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .block_size_in  (block_size_in),
    .abort          (abort),
    .ready_out      (ready_out),
    .target_reached (target_reached),
    .busy           (busy),
    .block_size     (block_size),
    .offset         (offset),
    .counter_clear  (counter_clear),
    .count_enable   (count_enable),
    .addr_valid     (addr_valid),
    .block_done     (block_done),
    .seq_error      (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached counter wrapper model: q clears or steps, address = {q, offset}.
  int q;
  int cur_l = 132;
  bit force_tr = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) q <= 0;
    else if (counter_clear) q <= 0;
    else if (count_enable) q <= q + 1;
  end

  assign target_reached = force_tr ||
    ((q == cur_l - 1) && (offset == 3'd7));

  // Results of the last run_block call.
  int r_beats;
  int r_bad_addr;
  int r_bad_exp;
  int r_bad_obs;
  int r_done_cyc;
  int r_done_cnt;
  bit r_timeout;
  bit r_bnd_clr;
  bit r_bnd_valid;
  int r_bnd_off;
  int r_first_p1;
  bit r_abort_ce;
  bit r_abort_clr;
  bit r_busy_after;
  bit r_err_clear;
  bit r_err_end;

  task automatic run_block(input bit size, input int ready_pct,
                           input int abort_idx, input int force_idx,
                           input int stop_idx);
    int l;
    int limit;
    int exp_a;
    int obs_a;
    bit prev_last;
    bit bnd_seen;
    bit ended;
    l = size ? 768 : 132;
    cur_l = l;
    limit = 8 * (1 + l) * 4 + 200;
    r_beats = 0; r_bad_addr = 0; r_done_cyc = -1; r_done_cnt = 0;
    r_timeout = 1'b0; r_first_p1 = -1; r_bnd_off = -1;
    r_bnd_clr = 1'b0; r_bnd_valid = 1'b1;
    r_abort_ce = 1'b1; r_abort_clr = 1'b0; r_busy_after = 1'b1;
    prev_last = 1'b0; bnd_seen = 1'b0; ended = 1'b0;
    start = 1'b1;
    block_size_in = size;
    @(posedge clk); #1;
    start = 1'b0;
    block_size_in = 1'($urandom_range(1));
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (stop_idx >= 0 && r_beats == stop_idx) begin
        ended = 1'b1;
        break;
      end
      ready_out = ($urandom_range(99) < ready_pct);
      abort = (abort_idx >= 0 && r_beats == abort_idx && addr_valid);
      if (abort) ready_out = 1'b1;
      force_tr = (force_idx >= 0 && r_beats == force_idx);
      start = 1'($urandom_range(1));
      #1;
      if (cyc == 0) r_err_clear = seq_error;
      if (prev_last && !bnd_seen) begin
        r_bnd_clr = counter_clear;
        r_bnd_valid = addr_valid;
        r_bnd_off = offset;
        bnd_seen = 1'b1;
      end
      prev_last = 1'b0;
      if (count_enable) begin
        exp_a = (r_beats % l) * 8 + r_beats / l;
        obs_a = q * 8 + offset;
        if (obs_a != exp_a) begin
          if (r_bad_addr == 0) begin
            r_bad_exp = exp_a;
            r_bad_obs = obs_a;
          end
          r_bad_addr++;
        end
        if (r_beats == l) r_first_p1 = obs_a;
        if (r_beats == l - 1) prev_last = 1'b1;
        r_beats++;
      end
      if (block_done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      if (abort) begin
        r_abort_ce = count_enable;
        r_abort_clr = counter_clear;
        @(posedge clk); #1;
        r_busy_after = busy;
        ended = 1'b1;
        break;
      end
      if (block_done) begin
        @(posedge clk); #1;
        ended = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    r_timeout = !ended;
    start = 1'b0;
    abort = 1'b0;
    force_tr = 1'b0;
    ready_out = 1'b0;
    r_err_end = seq_error;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    total++;
    if ({busy, block_size, offset, counter_clear, count_enable,
         addr_valid, block_done, seq_error} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b off=%0d clr=%b ce=%b av=%b bd=%b err=%b, want all 0",
               busy, offset, counter_clear, count_enable, addr_valid,
               block_done, seq_error);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset: busy=%b want 0", busy);
      end
    end
  endtask

  task automatic check_clean(input string tag, input int n);
    total++;
    if (r_timeout || r_beats != n || r_done_cnt != 1) begin
      bad++;
      $display("FAIL %s_count: beats=%0d done=%0d timeout=%b want beats=%0d done=1",
               tag, r_beats, r_done_cnt, r_timeout, n);
    end
    total++;
    if (r_bad_addr != 0) begin
      bad++;
      $display("FAIL %s_order: %0d bad addrs, first got %0d want %0d",
               tag, r_bad_addr, r_bad_obs, r_bad_exp);
    end
    total++;
    if (r_err_end !== 1'b0) begin
      bad++;
      $display("FAIL %s_seq_error: got %b want 0", tag, r_err_end);
    end
  endtask

  task automatic test_small;
    run_block(1'b0, 100, -1, -1, -1);
    check_clean("small", 1056);
    total++;
    if (r_done_cyc != 1064) begin
      bad++;
      $display("FAIL small_done_time: got %0d want 1064", r_done_cyc);
    end
    total++;
    if (r_bnd_clr !== 1'b1 || r_bnd_valid !== 1'b0 || r_bnd_off != 1) begin
      bad++;
      $display("FAIL pass_boundary: clr=%b av=%b off=%0d want 1 0 1",
               r_bnd_clr, r_bnd_valid, r_bnd_off);
    end
    total++;
    if (r_first_p1 != 1) begin
      bad++;
      $display("FAIL first_addr_p1: got %0d want 1", r_first_p1);
    end
  endtask

  task automatic test_large_random;
    run_block(1'b1, 50, -1, -1, -1);
    check_clean("large", 6144);
    total++;
    if (r_done_cyc < 6152) begin
      bad++;
      $display("FAIL large_done_time: got %0d want >=6152", r_done_cyc);
    end
  endtask

  task automatic test_abort;
    int extra_done;
    run_block(1'b0, 100, 3 * 132 + 10, -1, -1);
    total++;
    if (r_abort_ce !== 1'b0 || r_abort_clr !== 1'b1) begin
      bad++;
      $display("FAIL abort_cycle: ce=%b clr=%b want ce=0 clr=1",
               r_abort_ce, r_abort_clr);
    end
    total++;
    if (r_timeout || r_busy_after !== 1'b0 || r_beats != 3 * 132 + 10) begin
      bad++;
      $display("FAIL abort_idle: busy=%b beats=%0d to=%b want busy=0 beats=406",
               r_busy_after, r_beats, r_timeout);
    end
    extra_done = r_done_cnt;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (block_done || busy) extra_done++;
      @(posedge clk); #1;
    end
    total++;
    if (extra_done != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done/busy cycles want 0", extra_done);
    end
    run_block(1'b0, 80, -1, -1, -1);
    check_clean("after_abort", 1056);
  endtask

  task automatic test_checker;
    run_block(1'b0, 70, -1, 2 * 132 + 5, -1);
    total++;
    if (r_timeout || r_done_cnt != 1 || r_err_end !== 1'b1) begin
      bad++;
      $display("FAIL checker_sticky: err=%b done=%0d want err=1 done=1",
               r_err_end, r_done_cnt);
    end
    run_block(1'b0, 100, -1, -1, -1);
    total++;
    if (r_err_clear !== 1'b0) begin
      bad++;
      $display("FAIL checker_start_clears: err=%b want 0", r_err_clear);
    end
    check_clean("after_err", 1056);
  endtask

  task automatic test_reset_mid;
    run_block(1'b1, 100, -1, -1, 768 + 20);
    total++;
    if (busy !== 1'b1 || offset != 3'd1 || block_size !== 1'b1) begin
      bad++;
      $display("FAIL mid_run_state: busy=%b off=%0d bs=%b want 1 1 1",
               busy, offset, block_size);
    end
    ready_out = 1'b1;
    start = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({busy, block_size, offset, counter_clear, count_enable,
         addr_valid, block_done, seq_error} !== 10'd0) begin
      bad++;
      $display("FAIL async_reset: busy=%b bs=%b off=%0d clr=%b ce=%b av=%b",
               busy, block_size, offset, counter_clear, count_enable,
               addr_valid);
    end
    start = 1'b0;
    ready_out = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_idle: busy=%b want 0", busy);
      end
    end
    run_block(1'b0, 100, -1, -1, -1);
    check_clean("after_reset", 1056);
  endtask

  initial begin
    start = 1'b0;
    block_size_in = 1'b0;
    abort = 1'b0;
    ready_out = 1'b0;
    reset = 1'b0;
    test_reset();
    test_small();
    test_large_random();
    test_abort();
    test_checker();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
